nco_iq: RTL and testbench

NCO_IQ -- requirements
Module: nco_iq

---
 rtl/nco_iq_pkg.sv | 38 +++
 rtl/nco_quarter_lut.sv | 35 +++
 rtl/nco_iq.sv | 153 +++++++++++++++
 tb/tb_nco_iq.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nco_iq_pkg.sv
// Shared widths and quadrant encoding for the I/Q numerically controlled oscillator.
// Quadrant helpers tell the datapath when to mirror the LUT address and when to negate.
package nco_iq_pkg;

  localparam int PHASE_W_DEF = 32;
  localparam int CTRL_W_DEF  = 32;
  localparam int LUT_AW_DEF  = 8;
  localparam int OUT_W_DEF   = 16;

  typedef enum logic [1:0] {
    QUAD_0 = 2'd0,
    QUAD_1 = 2'd1,
    QUAD_2 = 2'd2,
    QUAD_3 = 2'd3
  } quad_t;

  // cos(x) = sin(x + pi/2): one quadrant ahead
  function automatic quad_t quad_advance(quad_t q);
    logic [1:0] v;
    v = q;
    return quad_t'(v + 2'd1);
  endfunction

  // Odd quadrants walk the quarter wave backwards.
  function automatic logic quad_mirror(quad_t q);
    logic [1:0] v;
    v = q;
    return v[0];
  endfunction

  // The lower half-plane is the negated upper half.
  function automatic logic quad_negate(quad_t q);
    logic [1:0] v;
    v = q;
    return v[1];
  endfunction

endpackage

// File: rtl/nco_quarter_lut.sv
// Quarter-wave sine magnitude ROM, sampled at half-step offsets so no entry is zero.
// Latency 1 cycle (registered read); always ready, no backpressure.
module nco_quarter_lut #(
  parameter int LUT_AW = 8,
  parameter int OUT_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [LUT_AW-1:0] addr,
  output logic [OUT_W-2:0]  data
);

  localparam int  DEPTH     = 1 << LUT_AW;
  localparam int  MAG_W     = OUT_W - 1;
  localparam int  FULLSCALE = (1 << (OUT_W - 1)) - 1;
  localparam real TWO_PI    = 6.283185307179586;

  logic [MAG_W-1:0] rom [DEPTH];

  // Every angle lies strictly inside (0, pi/2), so rounding up by 0.5 is a true round.
  for (genvar i = 0; i < DEPTH; i++) begin : g_rom
    localparam real ANGLE = TWO_PI * (real'(i) + 0.5) / real'(DEPTH * 4);
    localparam int  ENTRY = $rtoi(real'(FULLSCALE) * $sin(ANGLE) + 0.5);
    assign rom[i] = MAG_W'(ENTRY);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data <= '0;
    end else begin
      data <= rom[addr];
    end
  end

endmodule

// File: rtl/nco_iq.sv
// I/Q NCO: clamped fcw + correction drives a phase accumulator feeding a quarter-wave LUT.
// Latency 3 cycles from en to out_valid; no backpressure, one sample per en, fully pipelined.
module nco_iq
  import nco_iq_pkg::*;
#(
  parameter int PHASE_W = PHASE_W_DEF,
  parameter int CTRL_W  = CTRL_W_DEF,
  parameter int LUT_AW  = LUT_AW_DEF,
  parameter int OUT_W   = OUT_W_DEF
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      en,
  input  logic [PHASE_W-1:0]        fcw_base,
  input  logic signed [CTRL_W-1:0]  ctrl_in,
  input  logic                      phase_load,
  input  logic [PHASE_W-1:0]        phase_load_val,
  output logic signed [OUT_W-1:0]   cos_out,
  output logic signed [OUT_W-1:0]   sin_out,
  output logic [PHASE_W-1:0]        phase_out,
  output logic                      out_valid
);

  localparam int SUM_W = ((PHASE_W > CTRL_W) ? PHASE_W : CTRL_W) + 2;
  localparam int MAG_W = OUT_W - 1;

  logic signed [SUM_W-1:0] fcw_sum;
  logic [PHASE_W-1:0]      fcw_clamped;
  logic [PHASE_W-1:0]      fcw_eff;
  logic [PHASE_W-1:0]      phase;

  // Two guard bits keep the sum exact for any sign of correction.
  assign fcw_sum = $signed({{(SUM_W-PHASE_W){1'b0}}, fcw_base})
                 + $signed({{(SUM_W-CTRL_W){ctrl_in[CTRL_W-1]}}, ctrl_in});

  always_comb begin
    if (fcw_sum[SUM_W-1]) begin
      fcw_clamped = '0;
    end else if (|fcw_sum[SUM_W-2:PHASE_W]) begin
      fcw_clamped = '1;
    end else begin
      fcw_clamped = fcw_sum[PHASE_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fcw_eff <= '0;
      phase   <= '0;
    end else begin
      fcw_eff <= fcw_clamped;
      if (phase_load) begin
        phase <= phase_load_val;
      end else if (en) begin
        phase <= phase + fcw_eff;
      end
    end
  end

  // Stage 1: capture the pre-update phase and split it into quadrant and table address.
  logic               s1_vld;
  quad_t              s1_quad;
  logic [LUT_AW-1:0]  s1_addr;
  logic [PHASE_W-1:0] s1_phase;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_vld   <= 1'b0;
      s1_quad  <= QUAD_0;
      s1_addr  <= '0;
      s1_phase <= '0;
    end else begin
      s1_vld   <= en;
      s1_quad  <= quad_t'(phase[PHASE_W-1 -: 2]);
      s1_addr  <= phase[PHASE_W-3 -: LUT_AW];
      s1_phase <= phase;
    end
  end

  quad_t             cos_quad;
  logic [LUT_AW-1:0] sin_addr;
  logic [LUT_AW-1:0] cos_addr;
  logic [MAG_W-1:0]  sin_mag;
  logic [MAG_W-1:0]  cos_mag;

  assign cos_quad = quad_advance(s1_quad);
  assign sin_addr = quad_mirror(s1_quad)  ? ~s1_addr : s1_addr;
  assign cos_addr = quad_mirror(cos_quad) ? ~s1_addr : s1_addr;

  nco_quarter_lut #(
    .LUT_AW (LUT_AW),
    .OUT_W  (OUT_W)
  ) u_sin_lut (
    .clk     (clk),
    .reset_n (reset_n),
    .addr    (sin_addr),
    .data    (sin_mag)
  );

  nco_quarter_lut #(
    .LUT_AW (LUT_AW),
    .OUT_W  (OUT_W)
  ) u_cos_lut (
    .clk     (clk),
    .reset_n (reset_n),
    .addr    (cos_addr),
    .data    (cos_mag)
  );

  // Stage 2: travels alongside the LUT read.
  logic               s2_vld;
  logic               s2_sin_neg;
  logic               s2_cos_neg;
  logic [PHASE_W-1:0] s2_phase;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s2_vld     <= 1'b0;
      s2_sin_neg <= 1'b0;
      s2_cos_neg <= 1'b0;
      s2_phase   <= '0;
    end else begin
      s2_vld     <= s1_vld;
      s2_sin_neg <= quad_negate(s1_quad);
      s2_cos_neg <= quad_negate(cos_quad);
      s2_phase   <= s1_phase;
    end
  end

  logic signed [OUT_W-1:0] sin_pos;
  logic signed [OUT_W-1:0] cos_pos;

  assign sin_pos = $signed({1'b0, sin_mag});
  assign cos_pos = $signed({1'b0, cos_mag});

  // Stage 3: apply sign; outputs hold until the next valid sample.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sin_out   <= '0;
      cos_out   <= '0;
      phase_out <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= s2_vld;
      if (s2_vld) begin
        sin_out   <= s2_sin_neg ? -sin_pos : sin_pos;
        cos_out   <= s2_cos_neg ? -cos_pos : cos_pos;
        phase_out <= s2_phase;
      end
    end
  end

endmodule

// File: tb/tb_nco_iq.sv
// Scoreboard bench for nco_iq: a reference phase model queues expected samples on every en,
// a negedge monitor pops and compares them when out_valid fires.
module tb_nco_iq;

  localparam real PI = 3.141592653589793;

  logic               clk;
  logic               reset_n;
  logic               en;
  logic [31:0]        fcw_base;
  logic signed [31:0] ctrl_in;
  logic               phase_load;
  logic [31:0]        phase_load_val;
  logic signed [15:0] cos_out;
  logic signed [15:0] sin_out;
  logic [31:0]        phase_out;
  logic               out_valid;

  nco_iq dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .en             (en),
    .fcw_base       (fcw_base),
    .ctrl_in        (ctrl_in),
    .phase_load     (phase_load),
    .phase_load_val (phase_load_val),
    .cos_out        (cos_out),
    .sin_out        (sin_out),
    .phase_out      (phase_out),
    .out_valid      (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]        ph;
    logic signed [15:0] s;
    logic signed [15:0] c;
    int                 due;
  } exp_t;

  exp_t sb[$];
  exp_t lst;
  exp_t mon_e;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int pulse_cnt = 0;
  bit chk_mag = 1'b0;

  logic [31:0]        m_phase;
  logic [31:0]        m_fcw;
  logic [31:0]        cur_base;
  logic signed [31:0] cur_ctrl;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int lut(int i);
    return $rtoi(32767.0 * $sin(2.0 * PI * (real'(i) + 0.5) / 1024.0) + 0.5);
  endfunction

  function automatic logic signed [15:0] wave(logic [1:0] q, logic [7:0] a);
    int v;
    v = q[0] ? lut(255 - int'(a)) : lut(int'(a));
    return 16'(q[1] ? -v : v);
  endfunction

  function automatic logic signed [15:0] exp_sin(logic [31:0] ph);
    return wave(ph[31:30], ph[29:22]);
  endfunction

  function automatic logic signed [15:0] exp_cos(logic [31:0] ph);
    logic [1:0] q;
    q = ph[31:30] + 2'd1;
    return wave(q, ph[29:22]);
  endfunction

  function automatic logic [31:0] clamp(logic [31:0] b, logic signed [31:0] c);
    longint s;
    s = longint'({32'd0, b}) + longint'(c);
    if (s < 0) return 32'd0;
    if (s > 64'sd4294967295) return 32'hFFFF_FFFF;
    return 32'(s);
  endfunction

  // One clock of stimulus, with the reference model stepped to the upcoming edge.
  task automatic step(input bit e, input bit ld, input logic [31:0] ldv);
    exp_t x;
    @(negedge clk);
    en             = e;
    phase_load     = ld;
    phase_load_val = ldv;
    fcw_base       = cur_base;
    ctrl_in        = cur_ctrl;
    if (e) begin
      x.ph  = m_phase;
      x.s   = exp_sin(m_phase);
      x.c   = exp_cos(m_phase);
      x.due = cyc + 3;
      sb.push_back(x);
    end
    if (ld) m_phase = ldv;
    else if (e) m_phase = m_phase + m_fcw;
    m_fcw = clamp(cur_base, cur_ctrl);
  endtask

  task automatic drain(input string name);
    repeat (8) step(1'b0, 1'b0, 32'd0);
    n_chk++;
    if (sb.size() !== 0) begin
      n_fail++;
      $display("FAIL %s_drain: %0d samples never came out, expected 0 left", name, sb.size());
      sb.delete();
    end
  endtask

  always @(negedge clk) begin
    if (reset_n && out_valid) begin
      pulse_cnt++;
      n_chk++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL stale_pulse: out_valid at cycle %0d, expected no sample", cyc);
      end else begin
        mon_e = sb.pop_front();
        if (cyc !== mon_e.due) begin
          n_fail++;
          $display("FAIL latency: out_valid at cycle %0d, expected cycle %0d", cyc, mon_e.due);
        end
        n_chk++;
        if (phase_out !== mon_e.ph) begin
          n_fail++;
          $display("FAIL phase_out: got %h expected %h", phase_out, mon_e.ph);
        end
        n_chk++;
        if (sin_out !== mon_e.s) begin
          n_fail++;
          $display("FAIL sin_out: got %0d expected %0d (phase %h)", sin_out, mon_e.s, mon_e.ph);
        end
        n_chk++;
        if (cos_out !== mon_e.c) begin
          n_fail++;
          $display("FAIL cos_out: got %0d expected %0d (phase %h)", cos_out, mon_e.c, mon_e.ph);
        end
        if (chk_mag) begin
          longint mag;
          longint diff;
          mag  = longint'(sin_out) * longint'(sin_out) + longint'(cos_out) * longint'(cos_out);
          diff = mag - 64'sd1073676289;
          if (diff < 0) diff = -diff;
          n_chk++;
          if (diff * 1000 > 64'sd1073676289) begin
            n_fail++;
            $display("FAIL magnitude: got %0d expected 1073676289 +/-0.1%%", mag);
          end
        end
        lst = mon_e;
      end
    end else if (reset_n) begin
      n_chk++;
      if (phase_out !== lst.ph || sin_out !== lst.s || cos_out !== lst.c) begin
        n_fail++;
        $display("FAIL hold: got ph=%h s=%0d c=%0d expected ph=%h s=%0d c=%0d",
                 phase_out, sin_out, cos_out, lst.ph, lst.s, lst.c);
      end
    end
  end

  task automatic model_reset();
    sb.delete();
    m_phase = 32'd0;
    m_fcw   = 32'd0;
    lst.ph  = 32'd0;
    lst.s   = 16'sd0;
    lst.c   = 16'sd0;
    lst.due = 0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    en = 1'b1;
    fcw_base = 32'h4000_0000;
    ctrl_in = 32'sd0;
    phase_load = 1'b0;
    phase_load_val = 32'd0;
    model_reset();
    repeat (5) @(negedge clk);
    n_chk++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
    n_chk++;
    if (sin_out !== 16'sd0) begin n_fail++; $display("FAIL reset_sin: got %0d expected 0", sin_out); end
    n_chk++;
    if (cos_out !== 16'sd0) begin n_fail++; $display("FAIL reset_cos: got %0d expected 0", cos_out); end
    n_chk++;
    if (phase_out !== 32'd0) begin n_fail++; $display("FAIL reset_phase: got %h expected 0", phase_out); end
    en = 1'b0;
    reset_n = 1'b1;
  endtask

  task automatic test_quarter_rate();
    logic signed [15:0] ex_s;
    logic signed [15:0] ex_c;
    cur_base = 32'h4000_0000;
    cur_ctrl = 32'sd0;
    step(1'b0, 1'b0, 32'd0);
    repeat (12) step(1'b1, 1'b0, 32'd0);
    drain("quarter");
    ex_s = 16'(-lut(255));
    ex_c = 16'(lut(0));
    n_chk++;
    if (phase_out !== 32'hC000_0000) begin n_fail++; $display("FAIL quarter_phase: got %h expected c0000000", phase_out); end
    n_chk++;
    if (sin_out !== ex_s) begin n_fail++; $display("FAIL quarter_sin: got %0d expected %0d", sin_out, ex_s); end
    n_chk++;
    if (cos_out !== ex_c) begin n_fail++; $display("FAIL quarter_cos: got %0d expected %0d", cos_out, ex_c); end
  endtask

  task automatic test_clamp();
    cur_base = 32'hFFFF_FFF0;
    cur_ctrl = 32'sd100;
    step(1'b0, 1'b1, 32'd0);
    repeat (4) step(1'b1, 1'b0, 32'd0);
    drain("clamp_hi");
    n_chk++;
    if (phase_out !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL clamp_hi: got %h expected fffffffd", phase_out); end
    cur_base = 32'd5;
    cur_ctrl = 32'sh8000_0000;
    step(1'b0, 1'b0, 32'd0);
    repeat (3) step(1'b1, 1'b0, 32'd0);
    drain("clamp_lo");
    n_chk++;
    if (phase_out !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL clamp_lo_freeze: got %h expected fffffffc", phase_out); end
  endtask

  task automatic test_en_toggle();
    int c0;
    cur_base = 32'h0100_0000;
    cur_ctrl = -32'sd4096;
    step(1'b0, 1'b1, 32'h2000_0000);
    c0 = pulse_cnt;
    step(1'b1, 1'b0, 32'd0);
    step(1'b0, 1'b0, 32'd0);
    step(1'b0, 1'b0, 32'd0);
    step(1'b1, 1'b0, 32'd0);
    drain("en_toggle");
    n_chk++;
    if (pulse_cnt - c0 !== 2) begin n_fail++; $display("FAIL en_toggle_pulses: got %0d expected 2", pulse_cnt - c0); end
    n_chk++;
    if (phase_out !== 32'h20FF_F000) begin n_fail++; $display("FAIL en_toggle_step: got %h expected 20fff000", phase_out); end
  endtask

  task automatic test_load();
    cur_base = 32'h1000_0000;
    cur_ctrl = 32'sd0;
    step(1'b0, 1'b1, 32'h0000_0100);
    step(1'b1, 1'b0, 32'd0);
    step(1'b1, 1'b1, 32'h4000_0000);
    step(1'b1, 1'b0, 32'd0);
    step(1'b1, 1'b0, 32'd0);
    drain("load");
    n_chk++;
    if (phase_out !== 32'h5000_0000) begin n_fail++; $display("FAIL load_next: got %h expected 50000000", phase_out); end
  endtask

  task automatic test_reset_mid();
    int c0;
    cur_base = 32'h0800_0000;
    cur_ctrl = 32'sd0;
    step(1'b1, 1'b0, 32'd0);
    step(1'b1, 1'b0, 32'd0);
    step(1'b1, 1'b0, 32'd0);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    n_chk++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_valid: got %b expected 0", out_valid); end
    n_chk++;
    if (sin_out !== 16'sd0 || cos_out !== 16'sd0 || phase_out !== 32'd0) begin
      n_fail++;
      $display("FAIL midreset_out: got s=%0d c=%0d ph=%h expected all 0", sin_out, cos_out, phase_out);
    end
    model_reset();
    en = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    c0 = pulse_cnt;
    repeat (6) step(1'b0, 1'b0, 32'd0);
    n_chk++;
    if (pulse_cnt !== c0) begin n_fail++; $display("FAIL midreset_stale: got %0d pulses expected 0", pulse_cnt - c0); end
  endtask

  task automatic test_long_run();
    logic [31:0] ex_ph;
    cur_base = 32'h1234_5678;
    cur_ctrl = 32'sd0;
    chk_mag = 1'b1;
    step(1'b0, 1'b1, 32'd0);
    repeat (1000) step(1'b1, 1'b0, 32'd0);
    drain("long_run");
    chk_mag = 1'b0;
    ex_ph = 32'(longint'(999) * longint'(32'h1234_5678));
    n_chk++;
    if (phase_out !== ex_ph) begin n_fail++; $display("FAIL long_run_phase: got %h expected %h", phase_out, ex_ph); end
  endtask

  initial begin
    test_reset();
    test_quarter_rate();
    test_clamp();
    test_en_toggle();
    test_load();
    test_reset_mid();
    test_long_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
